// File: rtl/fft_stage_sequencer.sv
// -----------------------------------------------------------------------------
// fft_stage_sequencer
//
// Control sequencer for the FFT register stage. It loads N samples from the
// source, runs each of the NSTG stages in order, feeds every intermediate
// result back serially as the next stage's input, and finally presents the
// whole transform to the sink.
//
// Optional feature macro: FFT_WDOG_EN
//   When defined, a calculation watchdog aborts a stage that does not report
//   calc_finish within TIMEOUT cycles and sets the sticky err flag.
//   When undefined, err is tied low and CALC waits indefinitely.
//
// Ports
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous active-high reset
//   s_valid      in   1      input sample valid
//   s_data       in   MSB    input sample
//   s_ready      out  1      high only while loading samples
//   fill_regs    out  1      one-cycle pulse: start twiddle map fill
//   start_calc   out  1      one-cycle pulse: start stage computation
//   data_in      out  MSB    word written to the stage input registers
//   addr_counter out  AW     write address belonging to data_in
//   stage        out  SW     current stage index, 0..NSTG-1
//   fft_data_out in   N*MSB  stage result
//   calc_finish  in   1      stage result valid
//   m_valid      out  1      final result valid
//   m_data       out  N*MSB  final result (internal result latch)
//   m_ready      in   1      sink accepts the result
//   busy         out  1      sequencer not idle
//   err          out  1      sticky watchdog error
// -----------------------------------------------------------------------------
module fft_stage_sequencer #(
  parameter int N        = 16,
  parameter int MSB      = 16,
  parameter int FILL_CYC = N/2 + 2
`ifdef FFT_WDOG_EN
  ,
  parameter int TIMEOUT  = 255
`endif
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  input  logic [MSB-1:0]          s_data,
  output logic                    s_ready,
  output logic                    fill_regs,
  output logic                    start_calc,
  output logic [MSB-1:0]          data_in,
  output logic [$clog2(N)-1:0]    addr_counter,
  output logic [$clog2(N/4)-1:0]  stage,
  input  logic [N*MSB-1:0]        fft_data_out,
  input  logic                    calc_finish,
  output logic                    m_valid,
  output logic [N*MSB-1:0]        m_data,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    err
);

  localparam int NSTG = $clog2(N);
  localparam int AW   = $clog2(N);
  localparam int SW   = $clog2(N/4);
  localparam int FW   = $clog2(FILL_CYC + 1);
`ifdef FFT_WDOG_EN
  localparam int TW   = $clog2(TIMEOUT + 1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_FILL = 3'd2,
    CALC      = 3'd3,
    FEED      = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t             state;
  logic [AW-1:0]      cnt;       // word pointer for LOAD and FEED
  logic [FW-1:0]      fill_cnt;  // cycles since the last fill_regs pulse (saturating)
  logic [N*MSB-1:0]   latch;     // last stage result
`ifdef FFT_WDOG_EN
  logic [TW-1:0]      wdog_cnt;
  logic               err_r;
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

  assign m_data = latch;

  // Sequencer FSM: all outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      fill_cnt     <= '0;
      latch        <= '0;
      s_ready      <= 1'b0;
      fill_regs    <= 1'b0;
      start_calc   <= 1'b0;
      data_in      <= '0;
      addr_counter <= '0;
      stage        <= '0;
      m_valid      <= 1'b0;
      busy         <= 1'b0;
`ifdef FFT_WDOG_EN
      wdog_cnt     <= '0;
      err_r        <= 1'b0;
`endif
    end else begin
      // Pulses default low; the branch issuing one overrides.
      fill_regs  <= 1'b0;
      start_calc <= 1'b0;
      // The fill runs in the background of LOAD/FEED, so its timer runs freely.
      if (fill_cnt != FW'(FILL_CYC)) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
`ifdef FFT_WDOG_EN
      if (state == CALC && wdog_cnt != TW'(TIMEOUT)) begin
        wdog_cnt <= wdog_cnt + 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          // The word seen here is not consumed; it is accepted again in LOAD.
          if (s_valid) begin
            state     <= LOAD;
            s_ready   <= 1'b1;
            busy      <= 1'b1;
            stage     <= '0;
            cnt       <= '0;
            fill_regs <= 1'b1;
            fill_cnt  <= '0;
          end
        end
        LOAD: begin
          // s_ready is high throughout LOAD, so s_valid alone marks an accept.
          if (s_valid) begin
            data_in      <= s_data;
            addr_counter <= cnt;
            if (cnt == AW'(N - 1)) begin
              cnt     <= '0;
              s_ready <= 1'b0;
              state   <= WAIT_FILL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WAIT_FILL: begin
          // Leaving now puts start_calc FILL_CYC cycles after fill_regs at the earliest.
          if (fill_cnt >= FW'(FILL_CYC - 1)) begin
            state      <= CALC;
            start_calc <= 1'b1;
`ifdef FFT_WDOG_EN
            wdog_cnt   <= '0;
`endif
          end
        end
        CALC: begin
          if (calc_finish) begin
            latch <= fft_data_out;
            if (stage == SW'(NSTG - 1)) begin
              state   <= DONE;
              m_valid <= 1'b1;
            end else begin
              stage     <= stage + 1'b1;
              fill_regs <= 1'b1;
              fill_cnt  <= '0;
              cnt       <= '0;
              state     <= FEED;
            end
          end
`ifdef FFT_WDOG_EN
          else if (wdog_cnt == TW'(TIMEOUT)) begin
            err_r <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
            stage <= '0;
          end
`endif
        end
        FEED: begin
          // Replay the previous result one word per cycle as the next stage input.
          data_in      <= latch[int'(cnt)*MSB +: MSB];
          addr_counter <= cnt;
          if (cnt == AW'(N - 1)) begin
            cnt   <= '0;
            state <= WAIT_FILL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (m_ready) begin
            state   <= IDLE;
            m_valid <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
